// File: rtl/rv_mem_pkg.sv
// Shared types for the RV32I memory stage: load/store size codes,
// writeback source selects and the data-memory handshake FSM states.
package rv_mem_pkg;

  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } ls_size_e;

  localparam logic [1:0] ALU_SRC = 2'b00;
  localparam logic [1:0] MEM_SRC = 2'b01;
  localparam logic [1:0] PC_SRC  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  // Halfwords need an even address, words need a 4-byte aligned address.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic r;
    case (ls_size_e'(funct3))
      LS_H, LS_HU: r = addr_lo[0];
      LS_W:        r = (addr_lo != 2'b00);
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data memory: store byte enables and lane-replicated
// write data, plus load byte/half extraction with sign or zero extension.
module mem_lane_align
  import rv_mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_load_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_load_word[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_load_word[7:0];
      2'd1:    w_byte = i_load_word[15:8];
      2'd2:    w_byte = i_load_word[23:16];
      default: w_byte = i_load_word[31:24];
    endcase
  end

  assign w_half = i_addr_lo[1] ? i_load_word[31:16] : i_load_word[15:0];

  always_comb begin
    o_be        = 4'b1111;
    o_wdata     = i_store_data;
    o_load_data = i_load_word;
    case (ls_size_e'(i_funct3))
      LS_B: begin
        o_be        = 4'b0001 << i_addr_lo;
        o_wdata     = {4{i_store_data[7:0]}};
        o_load_data = {{24{w_byte[7]}}, w_byte};
      end
      LS_BU: begin
        o_be        = 4'b0001 << i_addr_lo;
        o_wdata     = {4{i_store_data[7:0]}};
        o_load_data = {24'd0, w_byte};
      end
      LS_H: begin
        o_be        = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata     = {2{i_store_data[15:0]}};
        o_load_data = {{16{w_half[15]}}, w_half};
      end
      LS_HU: begin
        o_be        = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata     = {2{i_store_data[15:0]}};
        o_load_data = {16'd0, w_half};
      end
      default: begin
        o_be        = 4'b1111;
        o_wdata     = i_store_data;
        o_load_data = i_load_word;
      end
    endcase
  end

endmodule

// File: rtl/stage_mem_access.sv
// RV32I memory stage: M pipeline register, data-memory handshake FSM and lane alignment.
// Optional macro MISALIGN_TRAP_EN flags misaligned H/W accesses instead of issuing them.
module stage_mem_access
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flushM,
  input  logic [1:0]        regSrcE,
  input  logic              regWriteE,
  input  logic              csrWriteE,
  input  logic              memReadE,
  input  logic              memWriteE,
  input  logic [2:0]        funct3E,
  input  logic [4:0]        rdAddrE,
  input  logic [11:0]       csrAddrE,
  input  logic [DATA_W-1:0] aluResultE,
  input  logic [DATA_W-1:0] writeDataE,
  input  logic [DATA_W-1:0] pcPlus4E,
  input  logic [DATA_W-1:0] csrResultE,
  output logic              stallM,
  output logic              dmemReq,
  output logic              dmemWe,
  output logic [ADDR_W-1:0] dmemAddr,
  output logic [DATA_W-1:0] dmemWdata,
  output logic [3:0]        dmemBe,
  input  logic              dmemReady,
  input  logic              dmemRvalid,
  input  logic [DATA_W-1:0] dmemRdata,
  output logic              misalignM,
  output logic [1:0]        regSrcM,
  output logic              regWriteM,
  output logic              csrWriteM,
  output logic [4:0]        rdAddrM,
  output logic [11:0]       csrAddrM,
  output logic [DATA_W-1:0] aluResultM,
  output logic [DATA_W-1:0] pcPlus4M,
  output logic [DATA_W-1:0] csrResultM,
  output logic [DATA_W-1:0] readDataM,
  output logic [1:0]        dbgStateM
);

  logic [1:0]        r_regSrc;
  logic              r_regWrite, r_csrWrite, r_memRead, r_memWrite;
  logic [2:0]        r_funct3;
  logic [4:0]        r_rdAddr;
  logic [11:0]       r_csrAddr;
  logic [DATA_W-1:0] r_aluResult, r_writeData, r_pcPlus4, r_csrResult;
  mem_state_e        r_state, w_next;

  logic              w_mem_op, w_misalign, w_issue;
  logic              w_req, w_stall, w_load_done;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata, w_load_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regSrc    <= '0;
      r_regWrite  <= 1'b0;
      r_csrWrite  <= 1'b0;
      r_memRead   <= 1'b0;
      r_memWrite  <= 1'b0;
      r_funct3    <= '0;
      r_rdAddr    <= '0;
      r_csrAddr   <= '0;
      r_aluResult <= '0;
      r_writeData <= '0;
      r_pcPlus4   <= '0;
      r_csrResult <= '0;
    end else if (!w_stall) begin
      if (flushM) begin
        r_regSrc    <= '0;
        r_regWrite  <= 1'b0;
        r_csrWrite  <= 1'b0;
        r_memRead   <= 1'b0;
        r_memWrite  <= 1'b0;
        r_funct3    <= '0;
        r_rdAddr    <= '0;
        r_csrAddr   <= '0;
        r_aluResult <= '0;
        r_writeData <= '0;
        r_pcPlus4   <= '0;
        r_csrResult <= '0;
      end else begin
        r_regSrc    <= regSrcE;
        r_regWrite  <= regWriteE;
        r_csrWrite  <= csrWriteE;
        r_memRead   <= memReadE;
        r_memWrite  <= memWriteE;
        r_funct3    <= funct3E;
        r_rdAddr    <= rdAddrE;
        r_csrAddr   <= csrAddrE;
        r_aluResult <= aluResultE;
        r_writeData <= writeDataE;
        r_pcPlus4   <= pcPlus4E;
        r_csrResult <= csrResultE;
      end
    end
  end

  assign w_mem_op = r_memRead | r_memWrite;

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = w_mem_op & is_misaligned(r_funct3, r_aluResult[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_issue = w_mem_op & ~w_misalign;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Handshake: a request is transferred on any cycle with dmemReq & dmemReady; the
  // request and its addr/we/be/wdata stay stable until then. Load data arrives on a
  // later cycle with dmemRvalid, which only counts while waiting in RESP.
  always_comb begin
    w_next      = r_state;
    w_req       = 1'b0;
    w_stall     = 1'b0;
    w_load_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_issue) begin
          w_req = 1'b1;
          if (dmemReady) begin
            if (!r_memWrite) begin
              w_next  = RESP;
              w_stall = 1'b1;
            end
          end else begin
            w_next  = REQ;
            w_stall = 1'b1;
          end
        end
      end
      REQ: begin
        w_req   = 1'b1;
        w_stall = 1'b1;
        if (dmemReady) begin
          if (r_memWrite) begin
            w_next  = IDLE;
            w_stall = 1'b0;
          end else begin
            w_next = RESP;
          end
        end
      end
      RESP: begin
        w_stall = 1'b1;
        if (dmemRvalid) begin
          w_stall     = 1'b0;
          w_load_done = 1'b1;
          w_next      = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  mem_lane_align u_align (
    .i_funct3     (r_funct3),
    .i_addr_lo    (r_aluResult[1:0]),
    .i_store_data (r_writeData),
    .i_load_word  (dmemRdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data)
  );

  assign stallM     = w_stall;
  assign dmemReq    = w_req;
  assign dmemWe     = w_req & r_memWrite;
  assign dmemAddr   = {r_aluResult[ADDR_W-1:2], 2'b00};
  assign dmemWdata  = r_memWrite ? w_wdata : '0;
  assign dmemBe     = w_issue ? w_be : 4'b0000;
  assign misalignM  = w_misalign;
  assign readDataM  = w_load_done ? w_load_data : '0;

  // Writeback sees a bubble while stalled or trapped; everything else is held as-is.
  assign regWriteM  = r_regWrite & ~w_stall & ~w_misalign;
  assign csrWriteM  = r_csrWrite & ~w_stall & ~w_misalign;
  assign regSrcM    = r_regSrc;
  assign rdAddrM    = r_rdAddr;
  assign csrAddrM   = r_csrAddr;
  assign aluResultM = r_aluResult;
  assign pcPlus4M   = r_pcPlus4;
  assign csrResultM = r_csrResult;
  assign dbgStateM  = r_state;

endmodule

// File: tb/tb_stage_mem_access.sv
// Randomized bench for stage_mem_access: the bench plays execute stage and data memory,
// predicting each cycle's outputs from a transaction-level model.
module tb_stage_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        flushM;
  logic [1:0]  regSrcE;
  logic        regWriteE, csrWriteE, memReadE, memWriteE;
  logic [2:0]  funct3E;
  logic [4:0]  rdAddrE;
  logic [11:0] csrAddrE;
  logic [31:0] aluResultE, writeDataE, pcPlus4E, csrResultE;
  logic        stallM, dmemReq, dmemWe;
  logic [31:0] dmemAddr, dmemWdata;
  logic [3:0]  dmemBe;
  logic        dmemReady, dmemRvalid;
  logic [31:0] dmemRdata;
  logic        misalignM;
  logic [1:0]  regSrcM;
  logic        regWriteM, csrWriteM;
  logic [4:0]  rdAddrM;
  logic [11:0] csrAddrM;
  logic [31:0] aluResultM, pcPlus4M, csrResultM, readDataM;
  logic [1:0]  dbgStateM;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  stage_mem_access dut (
    .clk(clk), .rst(rst), .flushM(flushM),
    .regSrcE(regSrcE), .regWriteE(regWriteE), .csrWriteE(csrWriteE),
    .memReadE(memReadE), .memWriteE(memWriteE), .funct3E(funct3E),
    .rdAddrE(rdAddrE), .csrAddrE(csrAddrE), .aluResultE(aluResultE),
    .writeDataE(writeDataE), .pcPlus4E(pcPlus4E), .csrResultE(csrResultE),
    .stallM(stallM), .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr),
    .dmemWdata(dmemWdata), .dmemBe(dmemBe), .dmemReady(dmemReady),
    .dmemRvalid(dmemRvalid), .dmemRdata(dmemRdata), .misalignM(misalignM),
    .regSrcM(regSrcM), .regWriteM(regWriteM), .csrWriteM(csrWriteM),
    .rdAddrM(rdAddrM), .csrAddrM(csrAddrM), .aluResultM(aluResultM),
    .pcPlus4M(pcPlus4M), .csrResultM(csrResultM), .readDataM(readDataM),
    .dbgStateM(dbgStateM)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [1:0] a);
    int ai = int'(a);
    case (f3)
      3'b000, 3'b100: return 32'(1 << ai);
      3'b001, 3'b101: return 32'(3 << (ai / 2 * 2));
      default:        return 32'd15;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return (d & 32'hFF) * 32'h01010101;
      3'b001:  return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * int'(a))) & 32'hFF;
    h = (w >> (16 * (int'(a) / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic model_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3 == 3'b001 || f3 == 3'b101) && a[0]) || (f3 == 3'b010 && a != 2'b00);
  endfunction

  task automatic drive_bubble();
    regSrcE = '0; regWriteE = 0; csrWriteE = 0; memReadE = 0; memWriteE = 0;
    funct3E = '0; rdAddrE = '0; csrAddrE = '0; aluResultE = '0; writeDataE = '0;
    pcPlus4E = '0; csrResultE = '0;
  endtask

  // driver: one instruction through M, acting as memory with the given latencies
  task automatic run_instr(input logic [1:0] src, input logic rw, input logic cw,
                           input logic mr, input logic mw, input logic [2:0] f3,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input logic [31:0] rdata, input logic flush,
                           input int d_rdy, input int d_val, input logic do_rst);
    logic [4:0]  rd;
    logic [11:0] csr;
    logic [31:0] pc4, csrv, mexp;
    logic        st;
    rd = 5'($urandom); csr = 12'($urandom); pc4 = $urandom; csrv = $urandom;
    @(negedge clk);
    regSrcE = src; regWriteE = rw; csrWriteE = cw; memReadE = mr; memWriteE = mw;
    funct3E = f3; rdAddrE = rd; csrAddrE = csr; aluResultE = alu; writeDataE = wd;
    pcPlus4E = pc4; csrResultE = csrv; flushM = flush;
    dmemReady = 0; dmemRvalid = 0;
    @(negedge clk);
    drive_bubble();
    flushM = 0;
    if (flush) begin
      #1;
      check("flush_req", dmemReq, 0);
      check("flush_stall", stallM, 0);
      check("flush_regwrite", regWriteM, 0);
      check("flush_csrwrite", csrWriteM, 0);
      return;
    end
`ifdef MISALIGN_TRAP_EN
    if ((mr || mw) && model_misaligned(f3, alu[1:0])) begin
      #1;
      check("mis_flag", misalignM, 1);
      check("mis_req", dmemReq, 0);
      check("mis_stall", stallM, 0);
      check("mis_regwrite", regWriteM, 0);
      return;
    end
`endif
    if (!(mr || mw)) begin
      dmemRvalid = 1'($urandom);
      #1;
      check("alu_req", dmemReq, 0);
      check("alu_stall", stallM, 0);
      check("alu_regwrite", regWriteM, rw);
      check("alu_csrwrite", csrWriteM, cw);
      check("alu_result", aluResultM, alu);
      check("alu_regsrc", regSrcM, src);
      check("alu_rd", rdAddrM, rd);
      check("alu_csraddr", csrAddrM, csr);
      check("alu_readdata", readDataM, 0);
      check("alu_misalign", misalignM, 0);
      return;
    end
    if (mr) exp_q.push_back(model_load(f3, alu[1:0], rdata));
    for (int c = 0; c <= d_rdy; c++) begin
      if (c > 0) @(negedge clk);
      dmemReady = (c == d_rdy); dmemRvalid = 1'($urandom);
      dmemRdata = $urandom; flushM = 1'($urandom);
      #1;
      st = mw ? (c < d_rdy) : 1'b1;
      check("req_valid", dmemReq, 1);
      check("req_we", dmemWe, mw);
      check("req_addr", dmemAddr, alu & 32'hFFFFFFFC);
      check("req_be", dmemBe, model_be(f3, alu[1:0]));
      check("req_stall", stallM, st);
      check("req_regwrite", regWriteM, rw & !st);
      check("req_csrwrite", csrWriteM, cw & !st);
      check("req_alu_hold", aluResultM, alu);
      check("req_pc4_hold", pcPlus4M, pc4);
      check("req_csrres_hold", csrResultM, csrv);
      check("req_readdata", readDataM, 0);
      check("req_misalign", misalignM, 0);
      if (mw) check("req_wdata", dmemWdata, model_wdata(f3, wd));
    end
    if (mw) return;
    for (int k = 0; k <= d_val; k++) begin
      @(negedge clk);
      dmemRvalid = (k == d_val); dmemReady = 1'($urandom);
      dmemRdata = (k == d_val) ? rdata : $urandom; flushM = 1'($urandom);
      #1;
      check("resp_req", dmemReq, 0);
      check("resp_stall", stallM, k < d_val);
      check("resp_regwrite", regWriteM, rw & (k == d_val));
      check("resp_csrwrite", csrWriteM, cw & (k == d_val));
      check("resp_rd_hold", rdAddrM, rd);
      check("resp_alu_hold", aluResultM, alu);
      if (k == d_val) begin
        mexp = exp_q.pop_front();
        check("load_data", readDataM, mexp);
      end else begin
        check("resp_readdata", readDataM, 0);
      end
      if (do_rst && k == 0 && d_val > 0) begin
        #2; rst = 0; #1;
        check("rst_req", dmemReq, 0);
        check("rst_stall", stallM, 0);
        check("rst_regwrite", regWriteM, 0);
        @(posedge clk); #1;
        check("rst_hold_req", dmemReq, 0);
        check("rst_hold_stall", stallM, 0);
        @(negedge clk);
        rst = 1;
        void'(exp_q.pop_front());
        return;
      end
    end
  endtask

  initial begin
    logic [2:0] ld_tab [5];
    int kind;
    logic [2:0] f3;
    int dr, dv;
    ld_tab[0] = 3'b000; ld_tab[1] = 3'b001; ld_tab[2] = 3'b010;
    ld_tab[3] = 3'b100; ld_tab[4] = 3'b101;
    rst = 0; flushM = 0; dmemReady = 0; dmemRvalid = 0; dmemRdata = '0;
    drive_bubble();
    repeat (2) @(negedge clk);
    #1;
    check("reset_req", dmemReq, 0);
    check("reset_stall", stallM, 0);
    check("reset_misalign", misalignM, 0);
    check("reset_regwrite", regWriteM, 0);
    check("reset_alu", aluResultM, 0);
    check("reset_be", dmemBe, 0);
    check("reset_readdata", readDataM, 0);
    @(negedge clk);
    rst = 1;

    run_instr(2'b00, 1, 0, 0, 0, 3'b010, 32'h1234, 0, 0, 0, 0, 0, 0);
    run_instr(2'b00, 0, 0, 0, 1, 3'b000, 32'h103, 32'hAB, 0, 0, 0, 0, 0);
    run_instr(2'b01, 1, 0, 1, 0, 3'b000, 32'h102, 0, 32'h00800000, 0, 2, 0, 0);
    run_instr(2'b01, 1, 0, 1, 0, 3'b101, 32'h102, 0, 32'h80010000, 0, 0, 0, 0);
    run_instr(2'b01, 1, 0, 1, 0, 3'b010, 32'h200, 0, 32'hDEADBEEF, 0, 0, 0, 0);
    run_instr(2'b01, 1, 0, 1, 0, 3'b010, 32'h300, 0, 32'h12345678, 0, 1, 2, 1);
    run_instr(2'b01, 1, 0, 1, 0, 3'b001, 32'h306, 0, 32'hF00D1234, 0, 0, 1, 0);
    run_instr(2'b01, 1, 0, 1, 0, 3'b010, 32'h101, 0, 32'hCAFEF00D, 0, 0, 0, 0);
    run_instr(2'b00, 1, 1, 0, 0, 3'b000, 32'h55, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 2);
      dr = $urandom_range(0, 3);
      dv = $urandom_range(0, 3);
      if (kind == 0) begin
        run_instr(2'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), 0, 0,
                  3'($urandom), $urandom, $urandom, 0, ($urandom_range(0, 7) == 0), 0, 0, 0);
      end else if (kind == 1) begin
        f3 = ld_tab[$urandom_range(0, 4)];
        run_instr(2'b01, 1'($urandom), 1'($urandom), 1, 0, f3, $urandom, $urandom, $urandom,
                  ($urandom_range(0, 9) == 0), dr, dv, ($urandom_range(0, 19) == 0));
      end else begin
        f3 = ld_tab[$urandom_range(0, 2)];
        run_instr(2'b00, 0, 1'($urandom), 0, 1, f3, $urandom, $urandom, 0,
                  ($urandom_range(0, 9) == 0), dr, 0, 0);
      end
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
